// File: rtl/interface_permn.sv
// -----------------------------------------------------------------------------
// interface_permn
// Input interface of the FFT butterfly array. Picks the IOBUF or FSC (stage
// feedback) source, applies an XOR-stride lane permutation and registers the
// result behind a single valid/ready output stage. Source select and
// permutation code are captured on the first beat of each frame and held for
// the remaining FRAME_LEN-1 beats. Every output beat carries a last-beat flag.
//
// Ports:
//   CLK, RSTN              clock, asynchronous active-low reset
//   SEL_ITR                source select (0 = IOBUF, 1 = FSC), sampled at frame start
//   SEL_PERM[LG]           permutation code, sampled at frame start
//   D_IOBUF / VALID_IOBUF / READY_IOBUF   IOBUF beat input
//   D_FSC   / VALID_FSC   / READY_FSC     feedback beat input
//   Q / Q_VALID / Q_READY / Q_LAST        registered permuted output beat
// Lane i of every bus occupies bits [i*DW +: DW].
// -----------------------------------------------------------------------------
module interface_permn #(
  parameter int DW        = 64,
  parameter int LANES     = 4,
  parameter int FRAME_LEN = 16
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       SEL_ITR,
  input  logic [$clog2(LANES)-1:0]   SEL_PERM,
  input  logic [LANES*DW-1:0]        D_IOBUF,
  input  logic                       VALID_IOBUF,
  output logic                       READY_IOBUF,
  input  logic [LANES*DW-1:0]        D_FSC,
  input  logic                       VALID_FSC,
  output logic                       READY_FSC,
  output logic [LANES*DW-1:0]        Q,
  output logic                       Q_VALID,
  input  logic                       Q_READY,
  output logic                       Q_LAST
);

  localparam int LG = $clog2(LANES);
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Registered state
  logic [LANES*DW-1:0] q_q,       q_d;
  logic                q_valid_q, q_valid_d;
  logic                q_last_q,  q_last_d;
  logic [CW-1:0]       cnt_q,     cnt_d;
  logic                itr_l_q,   itr_l_d;
  logic [LG-1:0]       perm_l_q,  perm_l_d;

  // Combinational helpers
  logic                cnt_zero_s;
  logic                eff_itr_s;
  logic [LG-1:0]       eff_perm_s;
  logic                stage_rdy_s;
  logic                acc_s;
  logic [LANES*DW-1:0] sel_bus_s;
  logic [LANES*DW-1:0] perm_bus_s;
  logic [DW-1:0]       sel_lane_s [LANES];

  // Effective configuration: live inputs on the first beat of a frame, locked copy afterwards.
  always_comb begin
    cnt_zero_s = (cnt_q == CNT_ZERO);
    if (cnt_zero_s) begin
      eff_itr_s  = SEL_ITR;
      eff_perm_s = SEL_PERM;
    end else begin
      eff_itr_s  = itr_l_q;
      eff_perm_s = perm_l_q;
    end
  end

  // Handshake and source mux; stage readiness is combinational so back-to-back beats flow.
  always_comb begin
    stage_rdy_s = !q_valid_q | Q_READY;
    if (eff_itr_s) begin
      sel_bus_s = D_FSC;
      acc_s     = stage_rdy_s & VALID_FSC;
    end else begin
      sel_bus_s = D_IOBUF;
      acc_s     = stage_rdy_s & VALID_IOBUF;
    end
  end

  assign READY_IOBUF = stage_rdy_s & !eff_itr_s;
  assign READY_FSC   = stage_rdy_s &  eff_itr_s;

  // Output lane i takes selected-bus lane (i XOR eff_perm); code 0 is identity.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign sel_lane_s[i]           = sel_bus_s[i*DW +: DW];
    assign perm_bus_s[i*DW +: DW]  = sel_lane_s[LG'(i) ^ eff_perm_s];
  end

  // Next-state logic for the output stage, frame counter and locked config.
  always_comb begin
    q_d       = q_q;
    q_valid_d = q_valid_q;
    q_last_d  = q_last_q;
    cnt_d     = cnt_q;
    itr_l_d   = itr_l_q;
    perm_l_d  = perm_l_q;
    if (acc_s) begin
      q_d       = perm_bus_s;
      q_valid_d = 1'b1;
      q_last_d  = (cnt_q == CNT_LAST);
      if (cnt_q == CNT_LAST) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
      // Capture the frame's config on its first beat only.
      if (cnt_zero_s) begin
        itr_l_d  = SEL_ITR;
        perm_l_d = SEL_PERM;
      end else begin
        itr_l_d  = itr_l_q;
        perm_l_d = perm_l_q;
      end
    end else if (Q_READY) begin
      q_valid_d = 1'b0;
    end else begin
      q_valid_d = q_valid_q;
    end
  end

  // State registers; reset drops any in-flight beat and restarts the frame.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q_q       <= {(LANES*DW){1'b0}};
      q_valid_q <= 1'b0;
      q_last_q  <= 1'b0;
      cnt_q     <= CNT_ZERO;
      itr_l_q   <= 1'b0;
      perm_l_q  <= {LG{1'b0}};
    end else begin
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      q_last_q  <= q_last_d;
      cnt_q     <= cnt_d;
      itr_l_q   <= itr_l_d;
      perm_l_q  <= perm_l_d;
    end
  end

  assign Q       = q_q;
  assign Q_VALID = q_valid_q;
  assign Q_LAST  = q_last_q;

endmodule

// File: tb/tb_interface_permn.sv
module tb_interface_permn;

  localparam int DW    = 64;
  localparam int LANES = 4;
  localparam int FL    = 4;
  localparam int W     = LANES * DW;

  logic          clk;
  logic          rstn;
  logic          sel_itr;
  logic [1:0]    sel_perm;
  logic [W-1:0]  d_iob, d_fsc, q;
  logic          v_iob, v_fsc, r_iob, r_fsc;
  logic          q_valid, q_ready, q_last;

  interface_permn #(.DW(DW), .LANES(LANES), .FRAME_LEN(FL)) dut (
    .CLK(clk), .RSTN(rstn),
    .SEL_ITR(sel_itr), .SEL_PERM(sel_perm),
    .D_IOBUF(d_iob), .VALID_IOBUF(v_iob), .READY_IOBUF(r_iob),
    .D_FSC(d_fsc), .VALID_FSC(v_fsc), .READY_FSC(r_fsc),
    .Q(q), .Q_VALID(q_valid), .Q_READY(q_ready), .Q_LAST(q_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counts accepted beats since reset, frame position = count mod FL.
  int           m_acc;
  logic         m_itr;
  logic [1:0]   m_perm;
  logic         m_valid, m_last;
  logic [W-1:0] m_q;

  typedef struct {
    logic        itr;
    logic [1:0]  perm;
    logic        vi, vf, qr;
    logic [63:0] iob, fsc;
    logic        e_ri, e_rf, e_qv, e_last;
    logic [63:0] e_base;
    logic [1:0]  e_perm;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_lanes(input logic [63:0] base);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = base + 64'(i);
    return r;
  endfunction

  function automatic logic [W-1:0] permute(input logic [W-1:0] s, input int p);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = s[(i ^ p)*DW +: DW];
    return r;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_itr = 1'b0; m_perm = 2'd0;
    m_valid = 1'b0; m_last = 1'b0; m_q = '0;
  endtask

  // One clock: drive at negedge, check readies, advance model, check outputs at next negedge.
  task automatic step(input logic itr, input logic [1:0] perm, input logic vi, input logic vf,
                      input logic qr, input logic [W-1:0] diob, input logic [W-1:0] dfsc,
                      output logic ri_o, output logic rf_o);
    int   pos;
    logic eitr, rdy, acc;
    logic [1:0] eperm;
    sel_itr = itr; sel_perm = perm; v_iob = vi; v_fsc = vf; q_ready = qr;
    d_iob = diob; d_fsc = dfsc;
    pos   = m_acc % FL;
    eitr  = (pos == 0) ? itr  : m_itr;
    eperm = (pos == 0) ? perm : m_perm;
    rdy   = !m_valid || qr;
    #1;
    ri_o = r_iob; rf_o = r_fsc;
    check("ready_iobuf", W'(r_iob), W'(rdy && !eitr));
    check("ready_fsc",   W'(r_fsc), W'(rdy && eitr));
    acc = rdy && (eitr ? vf : vi);
    if (acc) begin
      m_q     = permute(eitr ? dfsc : diob, int'(eperm));
      m_valid = 1'b1;
      m_last  = (pos == FL - 1);
      if (pos == 0) begin m_itr = itr; m_perm = perm; end
      m_acc++;
    end else if (qr) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("q_valid", W'(q_valid), W'(m_valid));
    if (m_valid) begin
      check("q_data", q, m_q);
      check("q_last", W'(q_last), W'(m_last));
    end
  endtask

  initial begin
    logic ri, rf;
    vec_t v;
    // Table: identity IOBUF, FSC permutes, mid-frame lock, bubbles, back-pressure.
    for (int k = 0; k < 8; k++)
      tbl.push_back('{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 64'h100 + 64'(16*k), 64'hF00 + 64'(16*k),
                      1'b1, 1'b0, 1'b1, (k % 4 == 3), 64'h100 + 64'(16*k), 2'd0});
    for (int k = 0; k < 4; k++)
      tbl.push_back('{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 64'h200 + 64'(16*k), 64'hA00 + 64'(16*k),
                      1'b0, 1'b1, 1'b1, (k == 3), 64'hA00 + 64'(16*k), 2'd1});
    for (int k = 0; k < 4; k++)
      tbl.push_back('{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 64'h200 + 64'(16*k), 64'hB00 + 64'(16*k),
                      1'b0, 1'b1, 1'b1, (k == 3), 64'hB00 + 64'(16*k), 2'd3});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 64'h300, 64'hC00, 1'b1, 1'b0, 1'b1, 1'b0, 64'h300, 2'd0});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 64'h310, 64'hC10, 1'b1, 1'b0, 1'b1, 1'b0, 64'h310, 2'd0});
    tbl.push_back('{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 64'h320, 64'hC20, 1'b1, 1'b0, 1'b1, 1'b0, 64'h320, 2'd0});
    tbl.push_back('{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 64'h330, 64'hC30, 1'b1, 1'b0, 1'b1, 1'b1, 64'h330, 2'd0});
    tbl.push_back('{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 64'h340, 64'hC40, 1'b0, 1'b1, 1'b1, 1'b0, 64'hC40, 2'd2});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 64'h350, 64'hC50, 1'b0, 1'b1, 1'b1, 1'b0, 64'hC50, 2'd2});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 64'h360, 64'hC60, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,   2'd0});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 64'h370, 64'hC70, 1'b0, 1'b1, 1'b1, 1'b0, 64'hC70, 2'd2});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 64'h380, 64'hC80, 1'b0, 1'b1, 1'b1, 1'b1, 64'hC80, 2'd2});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'h390, 64'hC90, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,   2'd0});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 64'h500, 64'hD00, 1'b1, 1'b0, 1'b1, 1'b0, 64'h500, 2'd0});
    for (int k = 0; k < 3; k++)
      tbl.push_back('{1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 64'h510, 64'hD10, 1'b0, 1'b0, 1'b1, 1'b0, 64'h500, 2'd0});
    tbl.push_back('{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 64'h510, 64'hD10, 1'b1, 1'b0, 1'b1, 1'b0, 64'h510, 2'd0});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'h520, 64'hD20, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,   2'd0});

    // Reset state
    rstn = 1'b0; sel_itr = 1'b0; sel_perm = 2'd0; v_iob = 1'b0; v_fsc = 1'b0;
    q_ready = 1'b0; d_iob = '0; d_fsc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_q", q, '0);
    check("rst_q_valid", W'(q_valid), W'(1'b0));
    check("rst_q_last", W'(q_last), W'(1'b0));
    rstn = 1'b1;

    // Table-driven directed vectors
    for (int t = 0; t < tbl.size(); t++) begin
      v = tbl[t];
      step(v.itr, v.perm, v.vi, v.vf, v.qr, mk_lanes(v.iob), mk_lanes(v.fsc), ri, rf);
      check($sformatf("tbl%0d_ready_iobuf", t), W'(ri), W'(v.e_ri));
      check($sformatf("tbl%0d_ready_fsc", t), W'(rf), W'(v.e_rf));
      check($sformatf("tbl%0d_q_valid", t), W'(q_valid), W'(v.e_qv));
      if (v.e_qv) begin
        check($sformatf("tbl%0d_q", t), q, permute(mk_lanes(v.e_base), int'(v.e_perm)));
        check($sformatf("tbl%0d_q_last", t), W'(q_last), W'(v.e_last));
      end
    end

    // Reset mid-frame with a beat held on Q (frame position 2 accepted, Q_READY low)
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, mk_lanes(64'h520), mk_lanes(64'hD20), ri, rf);
    check("pre_rst_q_valid", W'(q_valid), W'(1'b1));
    #2 rstn = 1'b0;
    #1;
    check("async_rst_q_valid", W'(q_valid), W'(1'b0));
    check("async_rst_q", q, '0);
    check("async_rst_q_last", W'(q_last), W'(1'b0));
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 2'd3, 1'b0, 1'b1, 1'b1, mk_lanes(64'h600), mk_lanes(64'hE00 + 64'(16*k)), ri, rf);
      check("post_rst_q", q, permute(mk_lanes(64'hE00 + 64'(16*k)), 3));
      check("post_rst_last", W'(q_last), W'(k == 3));
    end

    // Randomized stimulus against the model
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] ra, rb;
      for (int w = 0; w < W / 32; w++) begin
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0), ra, rb, ri, rf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
